pixel_window_buffer: RTL and testbench

//  Upstream feeder for the x/y convolution stages. Accepts a row-major stream
//  of 4-bit pixels and keeps two line buffers plus a 3x3 shift window. For

---
 rtl/pixel_window_buffer.sv | 169 ++++++++++++++++
 tb/tb_pixel_window_buffer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_window_buffer.sv
// pixel_window_buffer
// Streams row-major pixels through two line buffers and a 3x3 shift window.
// Each complete neighbourhood is handed to the convolver with a one-cycle
// calc_enable pulse, and the input stream is held off until calc_done.
module pixel_window_buffer #(
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8,
   parameter int PIX_W      = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  pix_valid,
   input  logic                                  pix_sof,
   input  logic [PIX_W-1:0]                      pix_data,
   output logic                                  pix_ready,
   input  logic                                  calc_done,
   output logic                                  calc_enable,
   output logic [2:0][2:0][PIX_W-1:0]            pixels,
   output logic [$clog2(IMG_HEIGHT)-1:0]         win_row,
   output logic [$clog2(IMG_WIDTH)-1:0]          win_col,
   output logic                                  frame_done
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST     = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_HEIGHT - 1);
   localparam logic [CW-1:0] WIN_COL_LAST = CW'(IMG_WIDTH - 2);
   localparam logic [RW-1:0] WIN_ROW_LAST = RW'(IMG_HEIGHT - 2);
   localparam logic [CW-1:0] COL_TWO      = CW'(2);
   localparam logic [RW-1:0] ROW_TWO      = RW'(2);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t                         r_state;
   state_t                         w_state_nxt;
   logic [CW-1:0]                  r_col;
   logic [RW-1:0]                  r_row;
   logic [CW-1:0]                  w_col_cur;
   logic [RW-1:0]                  w_row_cur;
   logic [CW-1:0]                  w_col_nxt;
   logic [RW-1:0]                  w_row_nxt;
   logic                           w_accept;
   logic                           w_issue;
   logic [PIX_W-1:0]               r_lb0 [IMG_WIDTH];
   logic [PIX_W-1:0]               r_lb1 [IMG_WIDTH];
   logic [2:0][2:0][PIX_W-1:0]     r_pixels;
   logic [RW-1:0]                  r_win_row;
   logic [CW-1:0]                  r_win_col;

   assign pix_ready = (r_state == S_FILL) & ~rst;
   assign w_accept  = pix_valid & pix_ready;
   // A start-of-frame pixel is always position (0,0), whatever the counters say.
   assign w_col_cur = pix_sof ? {CW{1'b0}} : r_col;
   assign w_row_cur = pix_sof ? {RW{1'b0}} : r_row;
   assign w_issue   = w_accept & (w_row_cur >= ROW_TWO) & (w_col_cur >= COL_TWO);

   assign pixels    = r_pixels;
   assign win_row   = r_win_row;
   assign win_col   = r_win_col;

   // Position of the pixel following the one being accepted (raster wrap).
   always_comb begin
      w_col_nxt = w_col_cur + CW'(1);
      w_row_nxt = w_row_cur;
      if (w_col_cur == COL_LAST) begin
         w_col_nxt = {CW{1'b0}};
         if (w_row_cur == ROW_LAST) begin
            w_row_nxt = {RW{1'b0}};
         end else begin
            w_row_nxt = w_row_cur + RW'(1);
         end
      end else begin
         w_row_nxt = w_row_cur;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state, start pulse and end-of-frame pulse.
   always_comb begin
      w_state_nxt = r_state;
      calc_enable = 1'b0;
      frame_done  = 1'b0;
      case (r_state)
         S_FILL: begin
            if (w_issue) begin
               w_state_nxt = S_ISSUE;
            end else begin
               w_state_nxt = S_FILL;
            end
         end
         S_ISSUE: begin
            calc_enable = 1'b1;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (calc_done) begin
               w_state_nxt = S_FILL;
               frame_done  = (r_win_row == WIN_ROW_LAST) & (r_win_col == WIN_COL_LAST);
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         default: begin
            w_state_nxt = S_FILL;
         end
      endcase
   end

   // Raster counters track the position of the next expected pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col <= {CW{1'b0}};
         r_row <= {RW{1'b0}};
      end else if (w_accept) begin
         r_col <= w_col_nxt;
         r_row <= w_row_nxt;
      end else begin
         r_col <= r_col;
         r_row <= r_row;
      end
   end

   // Line buffers and window shift; the window centre is latched on issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < IMG_WIDTH; i++) begin
            r_lb0[i] <= {PIX_W{1'b0}};
            r_lb1[i] <= {PIX_W{1'b0}};
         end
         r_pixels  <= '0;
         r_win_row <= {RW{1'b0}};
         r_win_col <= {CW{1'b0}};
      end else if (w_accept) begin
         for (int r = 0; r < 3; r++) begin
            r_pixels[r][0] <= r_pixels[r][1];
            r_pixels[r][1] <= r_pixels[r][2];
         end
         r_pixels[0][2]   <= r_lb1[w_col_cur];
         r_pixels[1][2]   <= r_lb0[w_col_cur];
         r_pixels[2][2]   <= pix_data;
         r_lb1[w_col_cur] <= r_lb0[w_col_cur];
         r_lb0[w_col_cur] <= pix_data;
         if (w_issue) begin
            r_win_row <= w_row_cur - RW'(1);
            r_win_col <= w_col_cur - CW'(1);
         end else begin
            r_win_row <= r_win_row;
            r_win_col <= r_win_col;
         end
      end else begin
         r_win_row <= r_win_row;
         r_win_col <= r_win_col;
      end
   end

endmodule

// File: tb/tb_pixel_window_buffer.sv
// Testbench for pixel_window_buffer: directed frames plus randomized stream,
// compared against an image-level reference model.
module tb_pixel_window_buffer;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int PW = 4;
   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       pix_valid;
   logic                       pix_sof;
   logic [PW-1:0]              pix_data;
   logic                       pix_ready;
   logic                       calc_done;
   logic                       calc_enable;
   logic [2:0][2:0][PW-1:0]    pixels;
   logic [RW-1:0]              win_row;
   logic [CW-1:0]              win_col;
   logic                       frame_done;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: image memory of the current frame plus handshake phase
   int img [H][W];
   int m_mode;          // 0 accepting, 1 window presented, 2 awaiting done
   int m_row, m_col;
   int m_wait, m_lat;
   bit m_last;
   bit g_rand_lat;
   int exp_pix [3][3];
   int exp_wr, exp_wc;
   int n_en, n_fd;

   pixel_window_buffer #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .PIX_W      (PW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pix_valid   (pix_valid),
      .pix_sof     (pix_sof),
      .pix_data    (pix_data),
      .pix_ready   (pix_ready),
      .calc_done   (calc_done),
      .calc_enable (calc_enable),
      .pixels      (pixels),
      .win_row     (win_row),
      .win_col     (win_col),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs, advance the model.
   task automatic cycle(input bit v, input bit s, input logic [PW-1:0] d,
                        input bit noise, output bit acc);
      int r, c;
      @(negedge clk);
      pix_valid = v;
      pix_sof   = s;
      pix_data  = d;
      if (m_mode == 2) calc_done = (m_wait == m_lat - 1);
      else             calc_done = noise && ($urandom_range(3) == 0);
      #1;
      check_val("pix_ready",   pix_ready,   m_mode == 0);
      check_val("calc_enable", calc_enable, m_mode == 1);
      check_val("frame_done",  frame_done,  (m_mode == 2) && calc_done && m_last);
      if (calc_enable === 1'b1) n_en++;
      if (frame_done === 1'b1)  n_fd++;
      if (m_mode == 1) begin
         check_val("win_row", win_row, exp_wr);
         check_val("win_col", win_col, exp_wc);
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               check_val("window_pix", pixels[i][j], exp_pix[i][j]);
      end
      acc = (m_mode == 0) && v;
      if (m_mode == 0) begin
         if (v) begin
            r = s ? 0 : m_row;
            c = s ? 0 : m_col;
            img[r][c] = int'(d);
            if (c == W - 1) begin
               m_col = 0;
               m_row = (r == H - 1) ? 0 : r + 1;
            end else begin
               m_col = c + 1;
               m_row = r;
            end
            if (r >= 2 && c >= 2) begin
               m_mode = 1;
               for (int i = 0; i < 3; i++)
                  for (int j = 0; j < 3; j++)
                     exp_pix[i][j] = img[r-2+i][c-2+j];
               exp_wr = r - 1;
               exp_wc = c - 1;
               m_last = (r - 1 == H - 2) && (c - 1 == W - 2);
            end
         end
      end else if (m_mode == 1) begin
         m_mode = 2;
         m_wait = 0;
         m_lat  = g_rand_lat ? int'($urandom_range(4, 1)) : 3;
      end else begin
         if (calc_done) m_mode = 0;
         else           m_wait++;
      end
   endtask

   task automatic check_reset_outputs();
      check_val("rst_ready",      pix_ready,   0);
      check_val("rst_calc_en",    calc_enable, 0);
      check_val("rst_frame_done", frame_done,  0);
      check_val("rst_pixels",     pixels,      0);
      check_val("rst_win_row",    win_row,     0);
      check_val("rst_win_col",    win_col,     0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst       = 1'b1;
      pix_valid = 1'b0;
      calc_done = 1'b1;
      #1;
      check_reset_outputs();
      @(negedge clk);
      #1;
      check_reset_outputs();
      rst       = 1'b0;
      calc_done = 1'b0;
      m_mode = 0; m_row = 0; m_col = 0; m_wait = 0; m_last = 1'b0;
   endtask

   // Directed frame with pixel(r,c) = 4r+c, continuous valid, sof on pixel 0.
   task automatic run_frame(input string name);
      int idx = 0;
      int guard = 0;
      bit acc;
      bit first_chk = 1'b0;
      logic [2:0][2:0][PW-1:0] e;
      logic [PW-1:0] d;
      n_en = 0;
      n_fd = 0;
      while (idx < W * H && guard < 400) begin
         d = idx[PW-1:0];
         cycle(1'b1, idx == 0, d, 1'b1, acc);
         if (acc) idx++;
         guard++;
         if (calc_enable === 1'b1 && n_en == 1 && !first_chk) begin
            first_chk = 1'b1;
            for (int i = 0; i < 3; i++)
               for (int j = 0; j < 3; j++)
                  e[i][j] = PW'(4 * i + j);
            check_val({name, "_first_win"}, pixels, e);
            check_val({name, "_first_row"}, win_row, 1);
            check_val({name, "_first_col"}, win_col, 1);
         end
      end
      check_val({name, "_feed_bound"}, guard < 400, 1);
      guard = 0;
      while (m_mode != 0 && guard < 40) begin
         cycle(1'b0, 1'b0, '0, 1'b1, acc);
         guard++;
      end
      check_val({name, "_drain_bound"}, guard < 40, 1);
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            e[i][j] = PW'(4 * i + j + 5);
      check_val({name, "_last_win"},   pixels, e);
      check_val({name, "_en_count"},   n_en, (W - 2) * (H - 2));
      check_val({name, "_done_count"}, n_fd, 1);
   endtask

   task automatic run_random(input int ncyc);
      bit acc;
      for (int k = 0; k < ncyc; k++)
         cycle($urandom_range(3) != 0, $urandom_range(59) == 0,
               PW'($urandom), 1'b1, acc);
   endtask

   initial begin
      bit acc;
      int guard;
      rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0; calc_done = 1'b0;
      m_mode = 0; m_row = 0; m_col = 0; m_wait = 0; m_lat = 3; m_last = 1'b0;
      g_rand_lat = 1'b0; n_en = 0; n_fd = 0;
      for (int i = 0; i < H; i++)
         for (int j = 0; j < W; j++)
            img[i][j] = 0;
      @(negedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_val("ready_after_reset", pix_ready, 1);

      run_frame("frame1");
      run_frame("frame2");

      g_rand_lat = 1'b1;
      run_random(1500);

      // reset while the convolver is still working on a window
      guard = 0;
      while (m_mode != 2 && guard < 300) begin
         cycle($urandom_range(3) != 0, 1'b0, PW'($urandom), 1'b1, acc);
         guard++;
      end
      check_val("reach_wait_bound", guard < 300, 1);
      apply_reset();
      run_random(600);
      run_frame("frame_after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
